// File: rtl/hazard_ctrl.sv
// Hazard and bypass controller for the 5-stage core: shadow pipe, EX bypass selects, load-use bubbles, flush.
// Build option HAZ_DM_BYPASS_EN enables the DM_WB-stage bypass; without it, EX_DM matches stall instead.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_stall,
  input  logic       flush,
  input  logic       rf_re0_ID,
  input  logic       rf_re1_ID,
  input  logic [3:0] rf_p0_addr,
  input  logic [3:0] rf_p1_addr,
  input  logic       rf_we_ID,
  input  logic [3:0] rf_dst_addr_ID,
  input  logic       mem_re_ID,
  output logic       byp0_EX,
  output logic       byp1_EX,
  output logic       byp0_DM,
  output logic       byp1_DM,
  output logic       stall_IF_ID,
  output logic       stall_ID_EX,
  output logic       stall_EX_DM,
  output logic       stall_DM_WB,
  output logic       bubble_ID_EX,
  output logic       rf_we_DM_WB,
  output logic [3:0] rf_dst_addr_DM_WB
);

  logic       we_ie, ld_ie, we_ed;
  logic [3:0] dst_ie, dst_ed;
  logic       m0_ie, m1_ie, m0_ed, m1_ed;
  logic       hz, kill;

  assign m0_ie = rf_re0_ID & we_ie & (rf_p0_addr == dst_ie) & (rf_p0_addr != 4'd0);
  assign m1_ie = rf_re1_ID & we_ie & (rf_p1_addr == dst_ie) & (rf_p1_addr != 4'd0);
  assign m0_ed = rf_re0_ID & we_ed & (rf_p0_addr == dst_ed) & (rf_p0_addr != 4'd0);
  assign m1_ed = rf_re1_ID & we_ed & (rf_p1_addr == dst_ed) & (rf_p1_addr != 4'd0);

`ifdef HAZ_DM_BYPASS_EN
  assign hz = (m0_ie | m1_ie) & ld_ie;
`else
  // Without the DM bypass, any operand still in EX_DM must wait one more cycle for WB.
  assign hz = ((m0_ie | m1_ie) & ld_ie) | (m0_ed & ~m0_ie) | (m1_ed & ~m1_ie);
`endif

  assign kill = hz | flush;

  // Reset forces a bubble and drops every stall so the pipe drains to a clean state.
  assign stall_ID_EX  = ~rst & ext_stall;
  assign stall_EX_DM  = ~rst & ext_stall;
  assign stall_DM_WB  = ~rst & ext_stall;
  assign stall_IF_ID  = ~rst & (ext_stall | (hz & ~flush));
  assign bubble_ID_EX = rst | (~ext_stall & kill);

  always_ff @(posedge clk) begin
    if (rst) begin
      we_ie             <= 1'b0;
      ld_ie             <= 1'b0;
      dst_ie            <= 4'd0;
      we_ed             <= 1'b0;
      dst_ed            <= 4'd0;
      rf_we_DM_WB       <= 1'b0;
      rf_dst_addr_DM_WB <= 4'd0;
      byp0_EX           <= 1'b0;
      byp1_EX           <= 1'b0;
    end else if (!ext_stall) begin
      rf_we_DM_WB       <= we_ed;
      rf_dst_addr_DM_WB <= dst_ed;
      we_ed             <= we_ie;
      dst_ed            <= dst_ie;
      if (kill) begin
        we_ie   <= 1'b0;
        ld_ie   <= 1'b0;
        dst_ie  <= 4'd0;
        byp0_EX <= 1'b0;
        byp1_EX <= 1'b0;
      end else begin
        we_ie   <= rf_we_ID;
        ld_ie   <= mem_re_ID;
        dst_ie  <= rf_dst_addr_ID;
        byp0_EX <= m0_ie & ~ld_ie;
        byp1_EX <= m1_ie & ~ld_ie;
      end
    end
  end

`ifdef HAZ_DM_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byp0_DM <= 1'b0;
      byp1_DM <= 1'b0;
    end else if (!ext_stall) begin
      if (kill) begin
        byp0_DM <= 1'b0;
        byp1_DM <= 1'b0;
      end else begin
        byp0_DM <= m0_ed & ~m0_ie;
        byp1_DM <= m1_ed & ~m1_ie;
      end
    end
  end
`else
  assign byp0_DM = 1'b0;
  assign byp1_DM = 1'b0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard and bypass controller for the 5-stage core.
- Tracks destination register, write-enable and load flag of every in-flight instruction in shadow ID_EX/EX_DM/DM_WB registers.
- Drives the EX-stage bypass selects (`byp0_EX`, `byp0_DM`, `byp1_EX`, `byp1_DM`) consumed by the source/bypass mux, and the per-stage stall signals (`stall_*`) for all pipeline registers.
- Inserts load-use bubbles and handles branch flushes.

## Interface
Parameters:
- none (register file fixed at 16 entries, 4-bit addresses, R0 hardwired zero)

Ports:
- `clk` in 1 – core clock
- `rst` in 1 – synchronous, active-high reset
- `ext_stall` in 1 – global freeze (memory wait); holds every pipeline stage
- `flush` in 1 – kill instruction in ID (taken branch/jump)
- `rf_re0_ID`, `rf_re1_ID` in 1 – ID instruction reads port 0 / port 1
- `rf_p0_addr`, `rf_p1_addr` in 4 – ID read addresses
- `rf_we_ID` in 1 – ID instruction writes RF
- `rf_dst_addr_ID` in 4 – ID destination
- `mem_re_ID` in 1 – ID instruction is a load (LW)
- `byp0_EX`, `byp1_EX` out 1 – registered; EX selects `dst_EX_DM` for port 0/1
- `byp0_DM`, `byp1_DM` out 1 – registered; EX selects `dst_DM_WB` for port 0/1
- `stall_IF_ID`, `stall_ID_EX`, `stall_EX_DM`, `stall_DM_WB` out 1 – hold stage register
- `bubble_ID_EX` out 1 – load NOP into ID_EX this cycle
- `rf_we_DM_WB` out 1 – RF write enable for WB
- `rf_dst_addr_DM_WB` out 4 – RF write address for WB

## Operation
- **Shadow pipe.** `{we, ld, dst}` advances ID→ID_EX→EX_DM→DM_WB on each clock where `ext_stall`=0. A bubble or flush loads `we`=0, `ld`=0 into ID_EX.
- **Match condition.**
  - `mX(stage)` = `rf_reX_ID` & `we_stage` & (`rf_pX_addr` == `dst_stage`) & (`rf_pX_addr` != 0).
  - Never raised for R0.
- **Bypass next-values.**
  - `bypX_EX_nxt` = `mX(ID_EX)` & !`ld_ID_EX`.
  - `bypX_DM_nxt` = `mX(EX_DM)` & !`mX(ID_EX)`, so EX priority is enforced here too.
  - Registered into the `byp` outputs when ID_EX advances. Loaded with 0 on bubble or flush.
- **Load-use hazard.**
  - `hz` = (`m0(ID_EX)` | `m1(ID_EX)`) & `ld_ID_EX`.
  - While `hz`: `stall_IF_ID`=1, `bubble_ID_EX`=1.
  - Next cycle the load sits in EX_DM, so `bypX_DM` resolves the operand. Penalty is exactly 1 cycle.
- **WB producer.** An instruction in DM_WB writes the RF this cycle. The RF is write-through, so no bypass or stall is needed.
- **Stall outputs.**
  - `stall_ID_EX` = `stall_EX_DM` = `stall_DM_WB` = `ext_stall`.
  - `stall_IF_ID` = `ext_stall` | (`hz` & !`flush`).
- **Bubble output.** `bubble_ID_EX` = !`ext_stall` & (`hz` | `flush`).
- **Flush.** Flush overrides `hz`: the killed instruction needs no operand, so there is no stall.
- **Priority.** `ext_stall` overrides everything. Shadow registers, `byp` outputs and hazard state all hold. `flush` must be held by its source until `ext_stall` drops.
- **Reset.** All shadow `we`/`ld`/`dst` = 0 and all `byp` outputs = 0. While `rst`=1, all `stall_*` = 0, `bubble_ID_EX` = 1, `rf_we_DM_WB` = 0 and `rf_dst_addr_DM_WB` = 0. Reset mid-stall discards the pending hazard.

## Timing
- Bypass selects: decided in ID, registered, valid for the whole EX cycle of the consumer.
- Stall/bubble: combinational from ID inputs and shadow registers, same cycle. No dependency on datapath values.
- `rf_we_DM_WB` and `rf_dst_addr_DM_WB` are direct register outputs.
- Back-to-back dependents each resolve independently. Example: LW R3; ADD R4,R3; SUB R5,R4 costs exactly 1 bubble total.

## Configuration
- Macro: `HAZ_DM_BYPASS_EN`.
- **Defined:** behaviour as above.
- **Undefined:**
  - `bypX_DM` outputs are tied to 0.
  - A match against EX_DM (`mX(EX_DM)` & !`mX(ID_EX)`) raises `hz` for 1 cycle, whether or not the producer is a load.
  - Load-use costs 2 cycles: first on the ID_EX match, then on the EX_DM match.
  - `bypX_EX` behaviour is unchanged.

## Test plan
- **EX bypass.** ADD R2 ← …; next instr reads R2 on p0. Expect `byp0_EX`=1 and `byp0_DM`=0 in the consumer's EX cycle, with no stall.
- **Double producer, EX priority.** ADD R2; ADD R2; SUB reads R2 on p1. Expect `byp1_EX`=1 and `byp1_DM`=0.
- **Load-use.** LW R3; ADD reads R3 on p0. Expect `stall_IF_ID`=1 and `bubble_ID_EX`=1 for exactly 1 cycle, then `byp0_DM`=1 in ADD's EX cycle.
- **R0 and unused ports.** LW R0; ADD reads R0 on p0. Expect no stall and all `byp`=0. Also: a match on `rf_p1_addr` with `rf_re1_ID`=0 gives no bypass.
- **Flush and ext_stall interaction.**
  - Load-use hazard with `flush`=1 in the same cycle: expect `stall_IF_ID`=0, `bubble_ID_EX`=1, ID_EX `we`=0.
  - `ext_stall`=1 for 3 cycles mid-sequence: expect all `stall_*`=1, `bubble_ID_EX`=0, and `byp` outputs frozen.
- **Reset and macro.** Assert `rst` during a load-use stall: expect all `byp`=0, all `stall_*`=0 and `rf_we_DM_WB`=0 the next cycle. Rerun the load-use scenario without `HAZ_DM_BYPASS_EN`: expect 2 bubble cycles and `byp0_DM` never asserted.
